mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 209 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: stage register, load-data alignment/extension, misaligned-load
// detection, combinational forwarding bus to ID and registered outputs to WB.
// Latency: one edge EX->MEM, one edge MEM->WB; the forwarding bus is combinational.
// Backpressure: stall freezes the stage and WB registers; flush squashes the stage register.
// A two-state capture FSM keeps the SRAM read word across a stall.
// Build option: define MEM_SUBWORD_LOAD_EN for lb/lbu/lh/lhu. Without it, every load is a word load.
// Ports:
//   clk, rst (async, active-low)
//   stall, flush : stage control
//   ex_*         : EX instruction (valid, wreg, load, load_op, waddr, pc, result)
//   data_sram_rdata : synchronous SRAM read word
//   mem_to_id_bus   : {wreg_eff, waddr, wdata}
//   wb_*         : registered WB outputs
//   adel         : misaligned-load flag
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic        ex_wreg,
  input  logic        ex_load,
  input  logic [2:0]  ex_load_op,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_result,
  input  logic [31:0] data_sram_rdata,
  output logic [37:0] mem_to_id_bus,
  output logic        wb_valid,
  output logic        wb_wreg,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_wdata,
  output logic        adel
);

  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } rd_state_e;

  // Stage register
  logic        r_valid_q, r_valid_d;
  logic        r_wreg_q, r_wreg_d;
  logic        r_load_q, r_load_d;
  logic [2:0]  r_load_op_q, r_load_op_d;
  logic [4:0]  r_waddr_q, r_waddr_d;
  logic [31:0] r_pc_q, r_pc_d;
  logic [31:0] r_result_q, r_result_d;

  // Read-data capture
  rd_state_e   state_q;
  logic [31:0] rdata_q;

  // WB registers
  logic        wb_valid_q, wb_wreg_q;
  logic [4:0]  wb_waddr_q;
  logic [31:0] wb_pc_q, wb_wdata_q;

  logic [1:0]  addr_lo;
  logic [31:0] rdata_sel;
  logic [31:0] load_data;
  logic        misalign;
  logic        adel_int;
  logic        wreg_eff;
  logic [31:0] wdata;

  // Flush outranks stall. Only valid/wreg are squashed. The remaining fields are
  // don't-care for a bubble, so they hold.
  always_comb begin
    r_valid_d   = r_valid_q;
    r_wreg_d    = r_wreg_q;
    r_load_d    = r_load_q;
    r_load_op_d = r_load_op_q;
    r_waddr_d   = r_waddr_q;
    r_pc_d      = r_pc_q;
    r_result_d  = r_result_q;
    if (flush) begin
      r_valid_d = 1'b0;
      r_wreg_d  = 1'b0;
    end else if (!stall) begin
      r_valid_d   = ex_valid;
      r_wreg_d    = ex_wreg;
      r_load_d    = ex_load;
      r_load_op_d = ex_load_op;
      r_waddr_d   = ex_waddr;
      r_pc_d      = ex_pc;
      r_result_d  = ex_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_q   <= 1'b0;
      r_wreg_q    <= 1'b0;
      r_load_q    <= 1'b0;
      r_load_op_q <= 3'b000;
      r_waddr_q   <= 5'd0;
      r_pc_q      <= 32'd0;
      r_result_q  <= 32'd0;
    end else begin
      r_valid_q   <= r_valid_d;
      r_wreg_q    <= r_wreg_d;
      r_load_q    <= r_load_d;
      r_load_op_q <= r_load_op_d;
      r_waddr_q   <= r_waddr_d;
      r_pc_q      <= r_pc_d;
      r_result_q  <= r_result_d;
    end
  end

  // The SRAM word is only valid in the first MEM cycle. On the first stalled edge of a
  // load, keep a copy. Return to the live port once the stage can move again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LIVE;
      rdata_q <= 32'd0;
    end else if (state_q == LIVE) begin
      if (stall && r_valid_q && r_load_q) begin
        state_q <= HELD;
        rdata_q <= data_sram_rdata;
      end
    end else begin
      if (!stall || flush) begin
        state_q <= LIVE;
      end
    end
  end

  assign rdata_sel = (state_q == HELD) ? rdata_q : data_sram_rdata;
  assign addr_lo   = r_result_q[1:0];

`ifdef MEM_SUBWORD_LOAD_EN
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_sel[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata_sel[31:16] : rdata_sel[15:0];

  // Reserved opcodes fall into the word path.
  always_comb begin
    load_data = rdata_sel;
    misalign  = (addr_lo != 2'b00);
    case (r_load_op_q)
      OP_LB: begin
        load_data = {{24{byte_sel[7]}}, byte_sel};
        misalign  = 1'b0;
      end
      OP_LBU: begin
        load_data = {24'd0, byte_sel};
        misalign  = 1'b0;
      end
      OP_LH: begin
        load_data = {{16{half_sel[15]}}, half_sel};
        misalign  = addr_lo[0];
      end
      OP_LHU: begin
        load_data = {16'd0, half_sel};
        misalign  = addr_lo[0];
      end
      default: begin
        load_data = rdata_sel;
        misalign  = (addr_lo != 2'b00);
      end
    endcase
  end
`else
  // Word-only build: load_op is carried but has no effect.
  logic unused_load_op;
  assign unused_load_op = ^r_load_op_q;
  assign load_data      = rdata_sel;
  assign misalign       = (addr_lo != 2'b00);
`endif

  assign adel_int = r_valid_q & r_load_q & misalign;
  assign wdata    = r_load_q ? load_data : r_result_q;
  assign wreg_eff = r_valid_q & r_wreg_q & ~adel_int;

  assign mem_to_id_bus = {wreg_eff, r_waddr_q, wdata};
  assign adel          = adel_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_wreg_q  <= 1'b0;
      wb_waddr_q <= 5'd0;
      wb_pc_q    <= 32'd0;
      wb_wdata_q <= 32'd0;
    end else if (!stall) begin
      wb_valid_q <= r_valid_q & ~adel_int;
      wb_wreg_q  <= wreg_eff;
      wb_waddr_q <= r_waddr_q;
      wb_pc_q    <= r_pc_q;
      wb_wdata_q <= wdata;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_wreg  = wb_wreg_q;
  assign wb_waddr = wb_waddr_q;
  assign wb_pc    = wb_pc_q;
  assign wb_wdata = wb_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic        ex_wreg;
  logic        ex_load;
  logic [2:0]  ex_load_op;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_pc;
  logic [31:0] ex_result;
  logic [31:0] data_sram_rdata;
  logic [37:0] mem_to_id_bus;
  logic        wb_valid;
  logic        wb_wreg;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_pc;
  logic [31:0] wb_wdata;
  logic        adel;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic        v;
    logic        w;
    logic        ld;
    logic [2:0]  op;
    logic [4:0]  wa;
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] rd;
  } instr_t;

  typedef struct packed {
    logic [37:0] bus;
    logic        adel;
    logic        v;
    logic        w;
    logic [4:0]  wa;
    logic [31:0] pc;
    logic [31:0] wd;
  } exp_t;

  exp_t sb_q[$];

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .ex_valid        (ex_valid),
    .ex_wreg         (ex_wreg),
    .ex_load         (ex_load),
    .ex_load_op      (ex_load_op),
    .ex_waddr        (ex_waddr),
    .ex_pc           (ex_pc),
    .ex_result       (ex_result),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_id_bus   (mem_to_id_bus),
    .wb_valid        (wb_valid),
    .wb_wreg         (wb_wreg),
    .wb_waddr        (wb_waddr),
    .wb_pc           (wb_pc),
    .wb_wdata        (wb_wdata),
    .adel            (adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference behaviour of one instruction sitting in MEM with read word i.rd.
  function automatic exp_t model(input instr_t i);
    exp_t        e;
    logic [1:0]  a;
    logic [31:0] ld_val;
    logic        mis;
    logic [7:0]  b;
    logic [15:0] h;
    a      = i.res[1:0];
    ld_val = i.rd;
    mis    = (a != 2'b00);
    b      = 8'(i.rd >> (32'(a) * 8));
    h      = 16'(i.rd >> (32'(a[1]) * 16));
`ifdef MEM_SUBWORD_LOAD_EN
    case (i.op)
      3'd1: begin ld_val = {{24{b[7]}}, b};  mis = 1'b0; end
      3'd2: begin ld_val = {24'd0, b};       mis = 1'b0; end
      3'd3: begin ld_val = {{16{h[15]}}, h}; mis = a[0]; end
      3'd4: begin ld_val = {16'd0, h};       mis = a[0]; end
      default: ;
    endcase
`endif
    e.adel = i.v & i.ld & mis;
    e.wd   = i.ld ? ld_val : i.res;
    e.w    = i.v & i.w & ~e.adel;
    e.v    = i.v & ~e.adel;
    e.wa   = i.wa;
    e.pc   = i.pc;
    e.bus  = {e.w, i.wa, e.wd};
    return e;
  endfunction

  task automatic drive(input instr_t i);
    ex_valid   = i.v;
    ex_wreg    = i.w;
    ex_load    = i.ld;
    ex_load_op = i.op;
    ex_waddr   = i.wa;
    ex_pc      = i.pc;
    ex_result  = i.res;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; data_sram_rdata = 32'h0;
    drive('0);
    #3 rst = 1'b0;
    #1;
    tests_run++; if (mem_to_id_bus !== 38'd0) begin tests_failed++; $display("FAIL reset_bus got=%h exp=0", mem_to_id_bus); end
    tests_run++; if (adel !== 1'b0) begin tests_failed++; $display("FAIL reset_adel got=%b exp=0", adel); end
    @(negedge clk);
    tests_run++; if (wb_valid !== 1'b0 || wb_wreg !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_flags got=%b%b exp=00", wb_valid, wb_wreg); end
    tests_run++; if (wb_waddr !== 5'd0 || wb_pc !== 32'd0 || wb_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset_wb_data got=%h/%h/%h exp=0", wb_waddr, wb_pc, wb_wdata); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Non-load ALU result forwarded and retired.
  task automatic test_alu;
    instr_t i;
    exp_t   e, g;
    i = '{v:1'b1, w:1'b1, ld:1'b0, op:3'd0, wa:5'd5, pc:32'h0000_0100, res:32'h0000_0007, rd:32'h0};
    @(negedge clk); drive(i);
    @(negedge clk); drive('0); data_sram_rdata = 32'hFFFF_FFFF; #1;
    e = model(i);
    tests_run++; if (mem_to_id_bus !== {1'b1, 5'd5, 32'h7}) begin tests_failed++; $display("FAIL alu_bus got=%h exp=%h", mem_to_id_bus, {1'b1, 5'd5, 32'h7}); end
    sb_q.push_back(e);
    @(negedge clk);
    g = sb_q.pop_front();
    tests_run++; if ({wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata} !== {g.v, g.w, g.wa, g.pc, g.wd}) begin
      tests_failed++; $display("FAIL alu_wb got=%b%b %h %h %h exp=%b%b %h %h %h", wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata, g.v, g.w, g.wa, g.pc, g.wd); end
  endtask

  // Isolated loads covering each load type and the alignment boundaries.
  task automatic test_loads;
    instr_t tbl[9];
    exp_t   e, g;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 3'd1, 5'd1, 32'h200, 32'h0000_1003, 32'h80FF_1234}; // lb a=3
    tbl[1] = '{1'b1, 1'b1, 1'b1, 3'd4, 5'd2, 32'h204, 32'h0000_1002, 32'h8001_ABCD}; // lhu a=2
    tbl[2] = '{1'b1, 1'b1, 1'b1, 3'd3, 5'd3, 32'h208, 32'h0000_1001, 32'h8001_ABCD}; // lh a=1
    tbl[3] = '{1'b1, 1'b1, 1'b1, 3'd0, 5'd4, 32'h20C, 32'h0000_1000, 32'h1234_5678}; // lw a=0
    tbl[4] = '{1'b1, 1'b1, 1'b1, 3'd0, 5'd6, 32'h210, 32'h0000_1002, 32'h1234_5678}; // lw a=2
    tbl[5] = '{1'b1, 1'b1, 1'b1, 3'd2, 5'd7, 32'h214, 32'h0000_1001, 32'h80FF_1234}; // lbu a=1
    tbl[6] = '{1'b1, 1'b1, 1'b1, 3'd3, 5'd8, 32'h218, 32'h0000_1000, 32'h0000_F00F}; // lh a=0
    tbl[7] = '{1'b1, 1'b1, 1'b1, 3'd7, 5'd9, 32'h21C, 32'h0000_1000, 32'hA5A5_A5A5}; // reserved op
    tbl[8] = '{1'b1, 1'b1, 1'b1, 3'd1, 5'd10, 32'h220, 32'h0000_1000, 32'h0000_007F}; // lb a=0
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); drive(tbl[k]);
      @(negedge clk); drive('0); data_sram_rdata = tbl[k].rd; #1;
      e = model(tbl[k]);
      tests_run++; if (mem_to_id_bus !== e.bus) begin tests_failed++; $display("FAIL load%0d_bus got=%h exp=%h", k, mem_to_id_bus, e.bus); end
      tests_run++; if (adel !== e.adel) begin tests_failed++; $display("FAIL load%0d_adel got=%b exp=%b", k, adel, e.adel); end
      sb_q.push_back(e);
      @(negedge clk);
      g = sb_q.pop_front();
      tests_run++; if ({wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata} !== {g.v, g.w, g.wa, g.pc, g.wd}) begin
        tests_failed++; $display("FAIL load%0d_wb got=%b%b %h %h %h exp=%b%b %h %h %h", k, wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata, g.v, g.w, g.wa, g.pc, g.wd); end
    end
  endtask

  // One instruction per cycle, random mix of loads and ALU ops.
  task automatic test_back_to_back;
    localparam int N = 24;
    instr_t ins[N];
    exp_t   e, g;
    for (int k = 0; k < N; k++) begin
      ins[k].v   = ($urandom_range(0, 7) != 0);
      ins[k].w   = 1'($urandom_range(0, 1));
      ins[k].ld  = 1'($urandom_range(0, 1));
      ins[k].op  = 3'($urandom_range(0, 7));
      ins[k].wa  = 5'($urandom);
      ins[k].pc  = $urandom;
      ins[k].res = $urandom;
      ins[k].rd  = $urandom;
    end
    for (int k = 0; k <= N + 1; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        g = sb_q.pop_front();
        tests_run++; if ({wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata} !== {g.v, g.w, g.wa, g.pc, g.wd}) begin
          tests_failed++; $display("FAIL b2b%0d_wb got=%b%b %h %h %h exp=%b%b %h %h %h", k - 2, wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata, g.v, g.w, g.wa, g.pc, g.wd); end
      end
      if (k < N) drive(ins[k]); else drive('0);
      if (k >= 1 && k <= N) begin
        data_sram_rdata = ins[k-1].rd;
        #1;
        e = model(ins[k-1]);
        tests_run++; if (mem_to_id_bus !== e.bus || adel !== e.adel) begin
          tests_failed++; $display("FAIL b2b%0d_bus got=%h/%b exp=%h/%b", k - 1, mem_to_id_bus, adel, e.bus, e.adel); end
        sb_q.push_back(e);
      end
    end
  endtask

  // Load held in MEM for three stalled cycles while the SRAM port changes underneath.
  task automatic test_stall_hold;
    instr_t i, j;
    exp_t   e, g, held;
    i = '{1'b1, 1'b1, 1'b1, 3'd0, 5'd12, 32'h300, 32'h0000_0100, 32'h1122_3344};
    j = '{1'b1, 1'b1, 1'b1, 3'd0, 5'd13, 32'h304, 32'h0000_0104, 32'hCAFE_F00D};
    held = model('0); // WB holds the bubble that preceded the load
    @(negedge clk); drive(i);
    @(negedge clk); drive('0); stall = 1'b1; data_sram_rdata = i.rd; #1;
    tests_run++; if (mem_to_id_bus[31:0] !== 32'h1122_3344) begin tests_failed++; $display("FAIL stall_c1_wdata got=%h exp=11223344", mem_to_id_bus[31:0]); end
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk); data_sram_rdata = 32'hDEAD_BEEF; #1;
      tests_run++; if (mem_to_id_bus[31:0] !== 32'h1122_3344) begin tests_failed++; $display("FAIL stall_c%0d_wdata got=%h exp=11223344", c, mem_to_id_bus[31:0]); end
      tests_run++; if ({wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata} !== {held.v, held.w, held.wa, held.pc, held.wd}) begin
        tests_failed++; $display("FAIL stall_c%0d_wb_hold got=%b%b %h %h %h", c, wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata); end
    end
    // Release: the held word is still presented up to the releasing edge.
    @(negedge clk); stall = 1'b0; drive(j); #1;
    e = model(i);
    tests_run++; if (mem_to_id_bus !== e.bus) begin tests_failed++; $display("FAIL stall_release_bus got=%h exp=%h", mem_to_id_bus, e.bus); end
    sb_q.push_back(e);
    @(negedge clk); drive('0); data_sram_rdata = j.rd;
    g = sb_q.pop_front();
    tests_run++; if ({wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata} !== {g.v, g.w, g.wa, g.pc, g.wd}) begin
      tests_failed++; $display("FAIL stall_wb got=%b%b %h %h %h exp=%b%b %h %h %h", wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata, g.v, g.w, g.wa, g.pc, g.wd); end
    #1;
    tests_run++; if (mem_to_id_bus[31:0] !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL stall_live_after got=%h exp=cafef00d", mem_to_id_bus[31:0]); end
    @(negedge clk);
  endtask

  // Stall and flush together: flush wins in the stage register, WB holds.
  task automatic test_flush;
    instr_t a, b;
    a = '{1'b1, 1'b1, 1'b0, 3'd0, 5'd9, 32'h2000, 32'h0000_0055, 32'h0};
    b = '{1'b1, 1'b1, 1'b0, 3'd0, 5'd10, 32'h2004, 32'h0000_0066, 32'h0};
    @(negedge clk); drive(a);
    @(negedge clk); drive(b); stall = 1'b1; flush = 1'b1; #1;
    tests_run++; if (mem_to_id_bus[37] !== 1'b1) begin tests_failed++; $display("FAIL flush_pre_wreg got=%b exp=1", mem_to_id_bus[37]); end
    @(negedge clk); drive('0); stall = 1'b0; flush = 1'b0; #1;
    tests_run++; if (mem_to_id_bus[37] !== 1'b0) begin tests_failed++; $display("FAIL flush_bus37 got=%b exp=0", mem_to_id_bus[37]); end
    tests_run++; if ({wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata} !== 71'd0) begin
      tests_failed++; $display("FAIL flush_wb_hold got=%b%b %h %h %h exp=0", wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata); end
    @(negedge clk);
    tests_run++; if (wb_valid !== 1'b0 || wb_wreg !== 1'b0) begin tests_failed++; $display("FAIL flush_wb_bubble got=%b%b exp=00", wb_valid, wb_wreg); end
  endtask

  // Asynchronous reset while a load is held under stall.
  task automatic test_reset_mid_stall;
    instr_t i, j;
    exp_t   e;
    i = '{1'b1, 1'b1, 1'b1, 3'd0, 5'd14, 32'h3000, 32'h0000_0040, 32'h7777_8888};
    j = '{1'b1, 1'b1, 1'b1, 3'd0, 5'd15, 32'h3100, 32'h0000_0008, 32'h5A5A_5A5A};
    @(negedge clk); drive(i);
    @(negedge clk); drive('0); stall = 1'b1; data_sram_rdata = i.rd;
    @(negedge clk); data_sram_rdata = 32'h0000_0001; #1;
    tests_run++; if (mem_to_id_bus[31:0] !== 32'h7777_8888) begin tests_failed++; $display("FAIL rstmid_held got=%h exp=77778888", mem_to_id_bus[31:0]); end
    rst = 1'b0; #1;
    tests_run++; if (mem_to_id_bus !== 38'd0 || adel !== 1'b0) begin tests_failed++; $display("FAIL rstmid_bus got=%h/%b exp=0/0", mem_to_id_bus, adel); end
    tests_run++; if ({wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata} !== 71'd0) begin
      tests_failed++; $display("FAIL rstmid_wb got=%b%b %h %h %h exp=0", wb_valid, wb_wreg, wb_waddr, wb_pc, wb_wdata); end
    @(negedge clk); rst = 1'b1; stall = 1'b0; drive(j);
    @(negedge clk); drive('0); data_sram_rdata = j.rd; #1;
    e = model(j);
    tests_run++; if (mem_to_id_bus !== e.bus) begin tests_failed++; $display("FAIL rstmid_live got=%h exp=%h", mem_to_id_bus, e.bus); end
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_alu();
    test_loads();
    test_back_to_back();
    test_stall_hold();
    test_flush();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
